// File: rtl/axis_frame_join_pkg.sv
// axis_frame_join shared definitions: sample width, frame length,
// FSM encodings, reset/enable polarity and a saturating counter helper.
package axis_frame_join_pkg;

  localparam int AXIS_TDATA_W = 32;
  localparam int FRAME_LEN    = 4096;
  localparam int FRAME_LEN_W  = $clog2(FRAME_LEN);

  localparam logic RST_ACTIVE = 1'b0;
  localparam logic EN_ON      = 1'b1;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == ERR_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_frame_join_if.sv
// AXI-Stream bundle: tvalid/tready/tlast/tdata.
// master drives valid/last/data, slave drives ready.
interface axis_frame_join_if
  import axis_frame_join_pkg::*;
#(
  parameter int DW = 2 * AXIS_TDATA_W
);

  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [DW-1:0] tdata;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    output tready
  );

endinterface

// File: rtl/axis_out_slice.sv
// Single-entry output register (data + last + valid).
// Ports: clk, rst_n, load/din/lin in, out_ready in, out_free out,
// out_valid/out_last/out_data registered stream outputs.
module axis_out_slice
  import axis_frame_join_pkg::*;
#(
  parameter int DW = 4 * AXIS_TDATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          lin,
  input  logic          out_ready,
  output logic          out_free,
  output logic          out_valid,
  output logic          out_last,
  output logic [DW-1:0] out_data
);

  // Free when empty or draining this cycle; valid itself
  // is purely registered.
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= EN_ON;
      out_last  <= lin;
      out_data  <= din;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_frame_join.sv
// Joins two framed 2-channel streams into one 4-channel stream,
// checks frame alignment, counts faults, resyncs on joint tlast.
// Ports: s00_axis_aclk, s00_axis_aresetn, s00_axis/s01_axis (slave),
// m00_axis (master), frame_locked, frame_err_cnt.
module axis_frame_join
  import axis_frame_join_pkg::state_t,
         axis_frame_join_pkg::ST_LOCK,
         axis_frame_join_pkg::ST_HUNT,
         axis_frame_join_pkg::RST_ACTIVE,
         axis_frame_join_pkg::sat_inc;
#(
  parameter int AXIS_TDATA_W =
    axis_frame_join_pkg::AXIS_TDATA_W,
  parameter int FRAME_LEN =
    axis_frame_join_pkg::FRAME_LEN
) (
  input  logic              s00_axis_aclk,
  input  logic              s00_axis_aresetn,
  axis_frame_join_if.slave  s00_axis,
  axis_frame_join_if.slave  s01_axis,
  axis_frame_join_if.master m00_axis,
  output logic              frame_locked,
  output logic [15:0]       frame_err_cnt
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int OW = 4 * AXIS_TDATA_W;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(FRAME_LEN - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [15:0]   err_n;
  logic          out_free;
  logic          fire;
  logic          load;
  logic          o_last;
  logic          l0;
  logic          l1;
  logic          last_exp;
  logic [OW-1:0] join_data;

  assign l0       = s00_axis.tlast;
  assign l1       = s01_axis.tlast;
  assign last_exp = (cnt == CNT_LAST);

  // Both inputs move together or not at all; reset
  // forces the readies low.
  assign fire = (s00_axis_aresetn != RST_ACTIVE)
             && s00_axis.tvalid
             && s01_axis.tvalid
             && out_free;

  assign s00_axis.tready = fire;
  assign s01_axis.tready = fire;

  assign join_data = {s01_axis.tdata, s00_axis.tdata};

  always_ff @(posedge s00_axis_aclk
              or negedge s00_axis_aresetn) begin
    if (s00_axis_aresetn == RST_ACTIVE) begin
      state         <= ST_LOCK;
      cnt           <= '0;
      frame_err_cnt <= '0;
      frame_locked  <= 1'b1;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      frame_err_cnt <= err_n;
      frame_locked  <= (state == ST_LOCK);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = frame_err_cnt;
    load    = 1'b0;
    o_last  = 1'b0;
    if (fire) begin
      if (state == ST_LOCK) begin
        load = 1'b1;
        unique case (1'b1)
          (l0 && l1 && last_exp): begin
            o_last = 1'b1;
            cnt_n  = '0;
          end
          (!l0 && !l1 && !last_exp): begin
            cnt_n = cnt + 1'b1;
          end
          // Early but aligned end: both sides
          // still agree, so lock is kept.
          (l0 && l1 && !last_exp): begin
            o_last = 1'b1;
            cnt_n  = '0;
            err_n  = sat_inc(frame_err_cnt);
          end
          default: begin
            o_last  = 1'b1;
            cnt_n   = '0;
            err_n   = sat_inc(frame_err_cnt);
            state_n = ST_HUNT;
          end
        endcase
      end else if (l0 && l1) begin
        // Joint tlast closes the broken frame;
        // the next beat starts a fresh one.
        state_n = ST_LOCK;
        cnt_n   = '0;
      end
    end
  end

  axis_out_slice #(
    .DW(OW)
  ) u_out (
    .clk       (s00_axis_aclk),
    .rst_n     (s00_axis_aresetn),
    .load      (load),
    .din       (join_data),
    .lin       (o_last),
    .out_ready (m00_axis.tready),
    .out_free  (out_free),
    .out_valid (m00_axis.tvalid),
    .out_last  (m00_axis.tlast),
    .out_data  (m00_axis.tdata)
  );

endmodule
